// File: rtl/l2_coherence_bus_arbiter.sv
// l2_coherence_bus_arbiter: round-robin arbiter serialising L2 read/write updates onto the single MESI directory port.
module l2_coherence_bus_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int MESI_STATE_WIDTH = 2,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_is_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [MESI_STATE_WIDTH-1:0]      resp_mesi,
  output logic [ADDRESS_WIDTH-1:0]         dir_addr,
  output logic                             dir_read_update,
  output logic                             dir_write_update,
  input  logic                             dir_verify,
  input  logic [MESI_STATE_WIDTH-1:0]      dir_mesi_state,
  output logic                             dir_ack,
  output logic                             timeout_error,
  output logic                             busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, DIR_REQ, DIR_ACK, RESP, RELEASE} state_t;
  state_t                      state_q, state_d;
  logic [NUM_REQ-1:0]          grant_q, grant_d, resp_valid_q, resp_valid_d;
  logic [MESI_STATE_WIDTH-1:0] mesi_q, mesi_d;
  logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic                        rd_q, rd_d, wr_q, wr_d, ack_q, ack_d, tmo_q, tmo_d, busy_q, busy_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [IW-1:0]               ptr_q, ptr_d, idx_q, idx_d, win, cand;
  logic [ADDRESS_WIDTH-1:0]    addr_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  end
  // Scan downward from the farthest offset so the closest requester at/after ptr_q wins last.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      win  = req[cand] ? cand : win;
    end
  end
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    resp_valid_d = '0;
    mesi_d       = mesi_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    ack_d        = 1'b0;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = DIR_REQ;
        grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
        idx_d   = win;
        addr_d  = addr_arr[win];
        rd_d    = !req_is_write[win];
        wr_d    = req_is_write[win];
        cnt_d   = '0;
      end
      DIR_REQ: if (dir_verify) begin
        state_d = DIR_ACK;
        mesi_d  = dir_mesi_state;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ack_d   = 1'b1;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d      = RESP;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        tmo_d        = 1'b1;
        mesi_d       = '0;
        resp_valid_d = grant_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DIR_ACK: begin
        state_d      = RESP;
        resp_valid_d = grant_q;
      end
      RESP: begin
        state_d = RELEASE;
        ptr_d   = IW'((int'(idx_q) + 1) % NUM_REQ);
      end
      RELEASE: if (!req[idx_q]) begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      resp_valid_q <= '0;
      mesi_q       <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ack_q        <= 1'b0;
      tmo_q        <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      mesi_q       <= mesi_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      ack_q        <= ack_d;
      tmo_q        <= tmo_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
    end
  end
  assign grant            = grant_q;
  assign resp_valid       = resp_valid_q;
  assign resp_mesi        = mesi_q;
  assign dir_addr         = addr_q;
  assign dir_read_update  = rd_q;
  assign dir_write_update = wr_q;
  assign dir_ack          = ack_q;
  assign timeout_error    = tmo_q;
  assign busy             = busy_q;
endmodule
